// File: rtl/decode_queue_if.sv
// decode_queue_pkg + decode_queue_if
//   Package: decoded instruction format produced by inst_decoder.
//   Interface: fetch-side and decode-side handshake bundle of decode_queue.
//     flush          pipeline flush request
//     fetch_valid/cnt/inst/pc/excp, fetch_ready   fetch bundle handshake
//     dec_valid/inst_d/pc/excp, dec_accept_cnt   decode lanes handshake
//     occupancy      entries stored in the queue
//   master = fetch/issue side (testbench or pipeline), slave = decode_queue.
package decode_queue_pkg;
   typedef enum logic [3:0] {
      ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
      ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
   } alu_op_t;

   typedef struct packed {
      alu_op_t     alu_op;
      logic [4:0]  src1;
      logic [4:0]  src2;
      logic [4:0]  dest;
      logic        rf_we;
      logic        use_imm;
      logic [31:0] imm;
      logic [4:0]  load_op;   // {lw, lhu, lh, lbu, lb}
      logic [2:0]  store_op;  // {sw, sh, sb}
      logic        invalid;
   } decoded_inst_t;
endpackage

interface decode_queue_if #(
   parameter int FETCH_WIDTH  = 2,
   parameter int DECODE_WIDTH = 2,
   parameter int DEPTH        = 8
);
   localparam int FCW = $clog2(FETCH_WIDTH + 1);
   localparam int DCW = $clog2(DECODE_WIDTH + 1);
   localparam int CW  = $clog2(DEPTH + 1);

   logic                                               flush;
   logic                                               fetch_valid;
   logic [FCW-1:0]                                     fetch_cnt;
   logic [FETCH_WIDTH-1:0][31:0]                       fetch_inst;
   logic [FETCH_WIDTH-1:0][31:0]                       fetch_pc;
   logic [FETCH_WIDTH-1:0]                             fetch_excp;
   logic                                               fetch_ready;
   logic [DECODE_WIDTH-1:0]                            dec_valid;
   decode_queue_pkg::decoded_inst_t [DECODE_WIDTH-1:0] dec_inst_d;
   logic [DECODE_WIDTH-1:0][31:0]                      dec_pc;
   logic [DECODE_WIDTH-1:0]                            dec_excp;
   logic [DCW-1:0]                                     dec_accept_cnt;
   logic [CW-1:0]                                      occupancy;

   modport master (
      output flush, fetch_valid, fetch_cnt, fetch_inst, fetch_pc, fetch_excp, dec_accept_cnt,
      input  fetch_ready, dec_valid, dec_inst_d, dec_pc, dec_excp, occupancy
   );
   modport slave (
      input  flush, fetch_valid, fetch_cnt, fetch_inst, fetch_pc, fetch_excp, dec_accept_cnt,
      output fetch_ready, dec_valid, dec_inst_d, dec_pc, dec_excp, occupancy
   );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: circular instruction queue between fetch and issue, with one
// combinational inst_decoder per output lane. Lanes present the oldest entries
// in program order; both sides use count-style handshakes.
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset (pointers/count only, data RAM kept)
//   bus    decode_queue_if.slave (fetch bundle in, decoded lanes out, flush)
// Build option: DECODE_QUEUE_BYPASS_EN lets lanes beyond the stored entries
// show the incoming fetch slots in the same cycle (0-cycle latency when empty).
module inst_decoder
   import decode_queue_pkg::*;
(
   input  logic [31:0]   inst_i,
   output decoded_inst_t dec_o
);
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, sa;
   logic [15:0] imm16;
   logic        itype;

   assign op    = inst_i[31:26];
   assign rs    = inst_i[25:21];
   assign rt    = inst_i[20:16];
   assign rd    = inst_i[15:11];
   assign sa    = inst_i[10:6];
   assign funct = inst_i[5:0];
   assign imm16 = inst_i[15:0];

   always_comb begin
      dec_o      = '0;
      itype      = 1'b0;
      dec_o.src1 = rs;
      dec_o.src2 = rt;
      dec_o.imm  = {{16{imm16[15]}}, imm16};
      case (op)
         6'h00: begin
            dec_o.dest  = rd;
            dec_o.rf_we = 1'b1;
            case (funct)
               6'h20, 6'h21: dec_o.alu_op = ALU_ADD;
               6'h22, 6'h23: dec_o.alu_op = ALU_SUB;
               6'h24:        dec_o.alu_op = ALU_AND;
               6'h25:        dec_o.alu_op = ALU_OR;
               6'h26:        dec_o.alu_op = ALU_XOR;
               6'h27:        dec_o.alu_op = ALU_NOR;
               6'h2a:        dec_o.alu_op = ALU_SLT;
               6'h2b:        dec_o.alu_op = ALU_SLTU;
               6'h00, 6'h02, 6'h03: begin
                  dec_o.alu_op  = (funct == 6'h00) ? ALU_SLL : (funct == 6'h02) ? ALU_SRL : ALU_SRA;
                  dec_o.use_imm = 1'b1;
                  dec_o.imm     = {27'b0, sa};
               end
               default: begin
                  dec_o.rf_we   = 1'b0;
                  dec_o.invalid = 1'b1;
               end
            endcase
         end
         6'h08, 6'h09: begin itype = 1'b1; dec_o.alu_op = ALU_ADD; end
         6'h0a:        begin itype = 1'b1; dec_o.alu_op = ALU_SLT; end
         6'h0b:        begin itype = 1'b1; dec_o.alu_op = ALU_SLTU; end
         6'h0c, 6'h0d, 6'h0e: begin
            itype        = 1'b1;
            dec_o.alu_op = (op == 6'h0c) ? ALU_AND : (op == 6'h0d) ? ALU_OR : ALU_XOR;
            dec_o.imm    = {16'b0, imm16};
         end
         6'h0f: begin itype = 1'b1; dec_o.alu_op = ALU_LUI; dec_o.imm = {imm16, 16'b0}; end
         6'h20: begin itype = 1'b1; dec_o.alu_op = ALU_ADD; dec_o.load_op = 5'b00001; end
         6'h24: begin itype = 1'b1; dec_o.alu_op = ALU_ADD; dec_o.load_op = 5'b00010; end
         6'h21: begin itype = 1'b1; dec_o.alu_op = ALU_ADD; dec_o.load_op = 5'b00100; end
         6'h25: begin itype = 1'b1; dec_o.alu_op = ALU_ADD; dec_o.load_op = 5'b01000; end
         6'h23: begin itype = 1'b1; dec_o.alu_op = ALU_ADD; dec_o.load_op = 5'b10000; end
         6'h28, 6'h29, 6'h2b: begin
            dec_o.alu_op   = ALU_ADD;
            dec_o.use_imm  = 1'b1;
            dec_o.store_op = (op == 6'h28) ? 3'b001 : (op == 6'h29) ? 3'b010 : 3'b100;
         end
         default: dec_o.invalid = 1'b1;
      endcase
      // I-type ops write rt from rs and the immediate
      if (itype) begin
         dec_o.dest    = rt;
         dec_o.rf_we   = 1'b1;
         dec_o.use_imm = 1'b1;
      end
   end
endmodule

module decode_queue #(
   parameter int FETCH_WIDTH  = 2,
   parameter int DECODE_WIDTH = 2,
   parameter int DEPTH        = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   decode_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
`ifdef DECODE_QUEUE_BYPASS_EN
   localparam bit BYPASS_EN = 1'b1;
`else
   localparam bit BYPASS_EN = 1'b0;
`endif

   logic [31:0] inst_q [DEPTH];
   logic [31:0] pc_q   [DEPTH];
   logic        excp_q [DEPTH];

   logic [PW-1:0] head_q, head_d, tail_q, tail_d, lane_idx;
   logic [CW-1:0] count_q, count_d;

   logic [DECODE_WIDTH-1:0][31:0] lane_inst;
   logic [DECODE_WIDTH-1:0]       lane_hit;
   logic [FETCH_WIDTH-1:0]        wr_en;
   logic [FETCH_WIDTH-1:0][PW-1:0] wr_idx;
   logic fetch_ready, enq;
   int   n_in, avail, deq, deq_st, deq_byp;

   // Registered count only: same-cycle dequeue does not free space
   assign fetch_ready     = !bus.flush && ((DEPTH - int'(count_q)) >= FETCH_WIDTH);
   assign bus.fetch_ready = fetch_ready;
   assign enq             = bus.fetch_valid && fetch_ready;
   assign bus.occupancy   = count_q;

   always_comb begin
      n_in     = 0;
      avail    = 0;
      lane_idx = '0;
      if (enq)
         n_in = (int'(bus.fetch_cnt) > FETCH_WIDTH) ? FETCH_WIDTH : int'(bus.fetch_cnt);
      for (int i = 0; i < DECODE_WIDTH; i++) begin
         lane_idx        = head_q + PW'(i);
         lane_hit[i]     = (i < int'(count_q));
         lane_inst[i]    = inst_q[lane_idx];
         bus.dec_pc[i]   = pc_q[lane_idx];
         bus.dec_excp[i] = excp_q[lane_idx];
         // Lanes past the stored entries pick up incoming slot (i - count)
         if (BYPASS_EN && !lane_hit[i]) begin
            for (int j = 0; j < FETCH_WIDTH; j++) begin
               if ((j == i - int'(count_q)) && (j < n_in)) begin
                  lane_hit[i]     = 1'b1;
                  lane_inst[i]    = bus.fetch_inst[j];
                  bus.dec_pc[i]   = bus.fetch_pc[j];
                  bus.dec_excp[i] = bus.fetch_excp[j];
               end
            end
         end
         bus.dec_valid[i] = lane_hit[i] && !bus.flush;
         if (bus.dec_valid[i]) avail = avail + 1;
      end
      deq     = (int'(bus.dec_accept_cnt) < avail) ? int'(bus.dec_accept_cnt) : avail;
      deq_st  = (deq < int'(count_q)) ? deq : int'(count_q);
      deq_byp = deq - deq_st;
      // Every accepted slot owns position tail+j; bypass-consumed slots are
      // skipped on write, and head steps past them together with tail.
      for (int j = 0; j < FETCH_WIDTH; j++) begin
         wr_en[j]  = (j >= deq_byp) && (j < n_in);
         wr_idx[j] = tail_q + PW'(j);
      end
      head_d  = head_q + PW'(deq);
      tail_d  = tail_q + PW'(n_in);
      count_d = CW'(int'(count_q) + n_in - deq);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || bus.flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      for (int j = 0; j < FETCH_WIDTH; j++) begin
         if (wr_en[j]) begin
            inst_q[wr_idx[j]] <= bus.fetch_inst[j];
            pc_q[wr_idx[j]]   <= bus.fetch_pc[j];
            excp_q[wr_idx[j]] <= bus.fetch_excp[j];
         end
      end
   end

   for (genvar i = 0; i < DECODE_WIDTH; i++) begin : g_lane
      inst_decoder u_dec (
         .inst_i (lane_inst[i]),
         .dec_o  (bus.dec_inst_d[i])
      );
   end
endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;
   import decode_queue_pkg::*;

   localparam logic [31:0] NOP = 32'h0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   decode_queue_if #(.FETCH_WIDTH(2), .DECODE_WIDTH(2), .DEPTH(8)) bus ();

   decode_queue #(.FETCH_WIDTH(2), .DECODE_WIDTH(2), .DEPTH(8)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] pc;
      logic        excp;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   pops   = 0;
   bit   mon_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One cycle: drive just after the rising edge, push the expected entries if
   // the bundle will be taken, then return at the falling edge for checks.
   task automatic cyc(input logic r, input logic fv, input int cnt, input logic [31:0] pc0,
                      input logic [31:0] i0, input logic [31:0] i1, input int acc,
                      input logic fl, output bit tk);
      logic [31:0] pc1;
      exp_t e;
      @(posedge clk);
      #1;
      pc1                = pc0 + 32'd4;
      rst                = r;
      bus.flush          = fl;
      bus.fetch_valid    = fv;
      bus.fetch_cnt      = 2'(cnt);
      bus.fetch_pc[0]    = pc0;
      bus.fetch_pc[1]    = pc1;
      bus.fetch_inst[0]  = i0;
      bus.fetch_inst[1]  = i1;
      bus.fetch_excp     = {pc1[4], pc0[4]};
      bus.dec_accept_cnt = 2'(acc);
      #1;
      tk = !r && fv && bus.fetch_ready;
      if (tk) begin
         for (int j = 0; j < cnt && j < 2; j++) begin
            e.pc   = (j == 0) ? pc0 : pc1;
            e.excp = (j == 0) ? pc0[4] : pc1[4];
            sb.push_back(e);
         end
      end
      @(negedge clk);
   endtask

   task automatic push(input int cnt, input logic [31:0] pc0, input int acc);
      bit tk;
      cyc(1'b0, 1'b1, cnt, pc0, NOP, NOP, acc, 1'b0, tk);
   endtask

   task automatic idle(input int acc);
      bit tk;
      cyc(1'b0, 1'b0, 0, 32'h0, NOP, NOP, acc, 1'b0, tk);
   endtask

   // Monitor: pops one expectation per consumed lane, in lane order
   always @(negedge clk) begin
      exp_t e;
      if (mon_en && !rst) begin
         if (bus.flush) begin
            chk("flush_mask", 32'(bus.dec_valid), 32'h0);
         end else begin
            chk("valid_prefix", 32'(bus.dec_valid & (bus.dec_valid + 2'd1)), 32'h0);
            for (int i = 0; i < 2; i++) begin
               if (i < int'(bus.dec_accept_cnt) && bus.dec_valid[i]) begin
                  if (sb.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL sb_underflow: lane %0d pc %h with nothing expected", i, bus.dec_pc[i]);
                  end else begin
                     e = sb.pop_front();
                     chk("lane_pc", bus.dec_pc[i], e.pc);
                     chk("lane_excp", 32'(bus.dec_excp[i]), 32'(e.excp));
                     pops++;
                  end
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit tk;
      int k, c, acc;
      rst                = 1'b1;
      bus.flush          = 1'b0;
      bus.fetch_valid    = 1'b0;
      bus.fetch_cnt      = '0;
      bus.fetch_inst     = '0;
      bus.fetch_pc       = '0;
      bus.fetch_excp     = '0;
      bus.dec_accept_cnt = '0;
      mon_en             = 1'b1;

      // Reset with a bundle offered
      cyc(1'b1, 1'b1, 2, 32'h100, NOP, NOP, 0, 1'b0, tk);
      cyc(1'b1, 1'b1, 2, 32'h100, NOP, NOP, 0, 1'b0, tk);
      chk("rst_valid", 32'(bus.dec_valid), 32'h0);
      chk("rst_occ", 32'(bus.occupancy), 32'd0);
      chk("rst_ready", 32'(bus.fetch_ready), 32'd1);
      idle(0);
      idle(0);
      chk("post_rst_occ", 32'(bus.occupancy), 32'd0);

      // Fill to full, stall, then drain
      pops = 0;
      for (int b = 0; b < 4; b++) begin
         push(2, 32'h1000 + 32'(8 * b), 0);
         chk("fill_occ", 32'(bus.occupancy), 32'(2 * b));
      end
      push(2, 32'h1100, 0);
      chk("full_occ", 32'(bus.occupancy), 32'd8);
      chk("full_ready", 32'(bus.fetch_ready), 32'd0);
      chk("full_valid", 32'(bus.dec_valid), 32'h3);
      push(2, 32'h1100, 2);
      chk("stall_occ", 32'(bus.occupancy), 32'd8);
      chk("stall_ready", 32'(bus.fetch_ready), 32'd0);
      idle(0);
      chk("after_deq_occ", 32'(bus.occupancy), 32'd6);
      chk("after_deq_ready", 32'(bus.fetch_ready), 32'd1);
      idle(2);
      idle(2);
      idle(2);
      idle(0);
      chk("drain_occ", 32'(bus.occupancy), 32'd0);
      chk("fill_pops", 32'(pops), 32'd8);

      // Order across pointer wraps, accept alternating 1 and 2
      pops = 0;
      k    = 0;
      c    = 0;
      while ((k < 20 || sb.size() > 0) && c < 200) begin
         acc = (c % 2 == 0) ? 1 : 2;
         if (k < 20) begin
            cyc(1'b0, 1'b1, 2, 32'hbfc00000 + 32'(4 * k), NOP, NOP, acc, 1'b0, tk);
            if (tk) k += 2;
         end else begin
            idle(acc);
         end
         c++;
      end
      chk("wrap_pops", 32'(pops), 32'd20);
      chk("wrap_sb_empty", 32'(sb.size()), 32'd0);
      idle(0);
      chk("wrap_occ", 32'(bus.occupancy), 32'd0);

      // Decode content
      cyc(1'b0, 1'b1, 2, 32'h2000, 32'h00851020, 32'h8c820004, 0, 1'b0, tk);
      idle(0);
      chk("dec_valid", 32'(bus.dec_valid), 32'h3);
      chk("dec0_alu", 32'(bus.dec_inst_d[0].alu_op), 32'(ALU_ADD));
      chk("dec0_rf_we", 32'(bus.dec_inst_d[0].rf_we), 32'd1);
      chk("dec0_dest", 32'(bus.dec_inst_d[0].dest), 32'd2);
      chk("dec0_load", 32'(bus.dec_inst_d[0].load_op), 32'd0);
      chk("dec1_lw", 32'(bus.dec_inst_d[1].load_op[4]), 32'd1);
      chk("dec1_dest", 32'(bus.dec_inst_d[1].dest), 32'd2);
      chk("dec1_rf_we", 32'(bus.dec_inst_d[1].rf_we), 32'd1);
      idle(2);
      idle(0);

      // fetch_cnt = 0 is a no-op
      push(0, 32'h4000, 0);
      idle(0);
      chk("cnt0_occ", 32'(bus.occupancy), 32'd0);
      chk("cnt0_valid", 32'(bus.dec_valid), 32'h0);

      // Excess accept is clamped
      push(1, 32'h4100, 0);
      idle(2);
      chk("clamp_valid", 32'(bus.dec_valid), 32'h1);
      idle(0);
      chk("clamp_occ", 32'(bus.occupancy), 32'd0);

      // Flush colliding with enqueue and dequeue at occupancy 5
      push(2, 32'h5000, 0);
      push(2, 32'h5008, 0);
      push(1, 32'h5010, 0);
      cyc(1'b0, 1'b1, 2, 32'h5018, NOP, NOP, 2, 1'b1, tk);
      chk("flush_occ_before", 32'(bus.occupancy), 32'd5);
      chk("flush_valid", 32'(bus.dec_valid), 32'h0);
      chk("flush_ready", 32'(bus.fetch_ready), 32'd0);
      sb.delete();
      push(2, 32'h6000, 0);
      chk("flush_occ_after", 32'(bus.occupancy), 32'd0);
      chk("flush_ready_after", 32'(bus.fetch_ready), 32'd1);
      idle(0);
      chk("post_flush_occ", 32'(bus.occupancy), 32'd2);
      idle(2);
      idle(0);

      // Empty queue, bundle offered and accepted in the same cycle
      push(2, 32'h7000, 2);
`ifdef DECODE_QUEUE_BYPASS_EN
      chk("byp_valid", 32'(bus.dec_valid), 32'h3);
      chk("byp_occ", 32'(bus.occupancy), 32'd0);
      idle(0);
      chk("byp_occ_next", 32'(bus.occupancy), 32'd0);
`else
      chk("nobyp_valid", 32'(bus.dec_valid), 32'h0);
      chk("nobyp_occ", 32'(bus.occupancy), 32'd0);
      idle(2);
      chk("nobyp_valid_next", 32'(bus.dec_valid), 32'h3);
      chk("nobyp_occ_next", 32'(bus.occupancy), 32'd2);
      idle(0);
      chk("nobyp_occ_drained", 32'(bus.occupancy), 32'd0);
`endif
      chk("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
